// File: rtl/mips_mem_pkg.sv
// Shared definitions for the memory-port arbiter.
//   - arb_state_e : arbiter FSM states (idle, fetch busy, data busy, done)
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
//   - GNT_I / GNT_D : grant-select encodings for the fetch and data requesters
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned STARVE_W   = 4;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StDone
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and the
// MEM-stage load/store path. One transfer per grant over a valid/ready bus; the
// winner gets a one-cycle ready pulse with captured read data.
//
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   if_req/if_addr              : fetch request (held until if_ready)
//   if_rdata/if_ready           : fetched word and completion pulse
//   d_read/d_write/d_addr/d_wdata : load/store request
//   d_rdata/d_ready             : load data and completion pulse
//   stall                       : pipeline freeze while any request is open
//   m_valid/m_we/m_addr/m_wdata : memory bus request (registered)
//   m_ready/m_rdata             : memory bus completion and read data
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_ready_q, d_ready_d;

    logic d_req;
    logic starve_ok;
    logic gnt_sel;

    assign d_req = d_read | d_write;
    // Data may win only while fetch has not yet waited STARVE_MAX transfers.
    assign starve_ok = (starve_cnt_q < StarveMax) || !if_req;
    assign gnt_sel = (state_q == StBusyD) ? GNT_D : GNT_I;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        m_valid_d    = m_valid_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (d_req && starve_ok) begin
                    state_d   = StBusyD;
                    m_valid_d = 1'b1;
                    m_we_d    = d_write;  // store wins if both are high
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    if (if_req && (starve_cnt_q != {STARVE_W{1'b1}})) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d      = StBusyI;
                    m_valid_d    = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = if_addr;
                    starve_cnt_d = '0;
                end
            end
            StBusyI, StBusyD: begin
                if (m_ready) begin
                    state_d   = StDone;
                    m_valid_d = 1'b0;
                    if (gnt_sel == GNT_D) begin
                        d_ready_d = 1'b1;
                        // A store leaves the load-data register untouched.
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = m_rdata;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            m_valid_q    <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            if_rdata_q   <= '0;
            if_ready_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            m_valid_q    <= m_valid_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            if_rdata_q   <= if_rdata_d;
            if_ready_q   <= if_ready_d;
            d_rdata_q    <= d_rdata_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign if_ready = if_ready_q;
    assign d_rdata  = d_rdata_q;
    assign d_ready  = d_ready_q;

    assign stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// phase, all checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall;
    logic        m_valid;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_rdata(if_rdata),
        .if_ready(if_ready),
        .d_read  (d_read),
        .d_write (d_write),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .stall   (stall),
        .m_valid (m_valid),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: one outstanding bus transaction, plus a one-cycle
    // completion slot during which no new grant may happen.
    logic        mb_busy, mb_is_d, mb_we, cool;
    logic [31:0] mb_addr, mb_wdata, mif_rdata, md_rdata;
    logic        exp_if_rdy, exp_d_rdy;
    int          starve, wait_cnt, cur_delay;

    // Stimulus controls.
    logic rdy_tied = 1'b0;
    logic rand_delay = 1'b0;
    logic d_auto = 1'b0;
    int   fixed_delay = 0;

    // Observed-bus bookkeeping.
    byte  grants[$];
    logic prev_valid = 1'b0;
    int   first_if_rdy, first_d_rdy, first_mv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mb_busy = 0; mb_is_d = 0; mb_we = 0; cool = 0;
        mb_addr = '0; mb_wdata = '0; mif_rdata = '0; md_rdata = '0;
        exp_if_rdy = 0; exp_d_rdy = 0;
        starve = 0; wait_cnt = 0; cur_delay = 0;
    endtask

    task automatic clear_marks();
        grants.delete();
        first_if_rdy = -1; first_d_rdy = -1; first_mv = -1;
    endtask

    // Effect of the clock edge closing the current cycle, from the current inputs.
    task automatic model_edge();
        logic nif, nd;
        nif = 0; nd = 0;
        if (!rst_n) return;
        if (mb_busy) begin
            if (m_ready) begin
                if (mb_is_d) begin
                    nd = 1;
                    if (!mb_we) md_rdata = m_rdata;
                end else begin
                    nif = 1;
                    mif_rdata = m_rdata;
                end
                mb_busy = 0;
                cool = 1;
            end else begin
                wait_cnt++;
            end
        end else if (cool) begin
            cool = 0;
        end else if ((d_read || d_write) && (starve < STARVE_MAX || !if_req)) begin
            mb_busy = 1; mb_is_d = 1; mb_we = d_write;
            mb_addr = d_addr; mb_wdata = d_wdata;
            if (if_req && starve < 15) starve++;
            wait_cnt = 0;
            cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        end else if (if_req) begin
            mb_busy = 1; mb_is_d = 0; mb_we = 0;
            mb_addr = if_addr;
            starve = 0;
            wait_cnt = 0;
            cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        end
        exp_if_rdy = nif;
        exp_d_rdy = nd;
    endtask

    task automatic step();
        logic exp_stall;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        exp_stall = (if_req & ~exp_if_rdy) | ((d_read | d_write) & ~exp_d_rdy);
        chk("m_valid", m_valid, mb_busy);
        if (mb_busy) begin
            chk("m_addr", m_addr, mb_addr);
            chk("m_we", m_we, mb_we);
            if (mb_we) chk("m_wdata", m_wdata, mb_wdata);
        end
        chk("if_ready", if_ready, exp_if_rdy);
        chk("d_ready", d_ready, exp_d_rdy);
        chk("if_rdata", if_rdata, mif_rdata);
        chk("d_rdata", d_rdata, md_rdata);
        chk("stall", stall, exp_stall);
        if (m_valid && !prev_valid) begin
            grants.push_back(m_addr[22] ? 8'h49 : 8'h44);  // 'I' or 'D'
            if (first_mv < 0) first_mv = cyc;
        end
        prev_valid = m_valid;
        if (if_ready && first_if_rdy < 0) first_if_rdy = cyc;
        if (d_ready && first_d_rdy < 0) first_d_rdy = cyc;
        // Requesters drop (or renew) once their completion pulse is seen.
        if (exp_if_rdy) if_req = 0;
        if (exp_d_rdy) begin
            if (d_auto) d_addr = d_addr + 32'd4;
            else begin d_read = 0; d_write = 0; end
        end
        // Memory responder.
        if (rdy_tied) m_ready = 1;
        else if (mb_busy) m_ready = (wait_cnt >= cur_delay);
        else m_ready = rand_delay ? 1'($urandom_range(0, 1)) : 1'b0;
        m_rdata = $urandom;
    endtask

    initial begin
        int t0;
        string pat;
        int op;
        model_reset();
        clear_marks();

        // Reset values.
        step(); step();
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_wdata", m_wdata, 0);
        rst_n = 1;
        step();

        // Fetch only, m_ready tied high.
        rdy_tied = 1; clear_marks();
        if_addr = 32'h0040_0000; if_req = 1; t0 = cyc;
        repeat (5) step();
        chk("fetch_mv_cyc", first_mv - t0, 1);
        chk("fetch_rdy_cyc", first_if_rdy - t0, 2);
        chk("fetch_ntransfers", grants.size(), 1);

        // Simultaneous fetch and load, 3-cycle memory delay.
        rdy_tied = 0; fixed_delay = 3; clear_marks();
        if_addr = 32'h0040_0100; if_req = 1;
        d_addr = 32'h0000_1000; d_read = 1; t0 = cyc;
        repeat (14) step();
        chk("sim_d_rdy_cyc", first_d_rdy - t0, 5);
        chk("sim_ngrants", grants.size(), 2);
        chk("sim_first_d", grants.size() > 0 ? grants[0] : 8'h0, 8'h44);
        chk("sim_then_i", grants.size() > 1 ? grants[1] : 8'h0, 8'h49);

        // Store: m_we and m_wdata held while waiting, d_rdata unchanged.
        fixed_delay = 2;
        d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_write = 1; d_read = 0;
        step(); step();
        chk("store_we", m_we, 1);
        chk("store_wdata", m_wdata, 32'hDEAD_BEEF);
        repeat (5) step();
        chk("store_drdata_kept", d_rdata, md_rdata);

        // Read and write together: store wins.
        d_addr = 32'h0000_2004; d_wdata = $urandom; d_read = 1; d_write = 1;
        step(); step();
        chk("both_we", m_we, 1);
        repeat (5) step();

        // Starvation bound: continuous loads with fetch held.
        rdy_tied = 1; d_auto = 1; clear_marks();
        if_addr = 32'h0040_0200; if_req = 1;
        d_addr = 32'h0000_1100; d_read = 1; d_write = 0;
        repeat (24) step();
        d_auto = 0;
        repeat (6) step();
        pat = "DDDDIDD";
        for (int k = 0; k < 7; k++) begin
            chk("starve_order", k < grants.size() ? grants[k] : 8'h0, pat[k]);
        end

        // Async reset during a data transfer.
        rdy_tied = 0; fixed_delay = 5;
        d_addr = 32'h0000_3000; d_read = 1; d_write = 0;
        step(); step();
        chk("rst_pre_valid", m_valid, 1);
        #3 rst_n = 0;
        #1;
        chk("rst_async_valid", m_valid, 0);
        chk("rst_async_dready", d_ready, 0);
        model_reset();
        d_read = 0; m_ready = 0; prev_valid = 0;
        step(); step();
        rst_n = 1;
        step();
        clear_marks();
        d_addr = 32'h0000_3004; d_read = 1; t0 = cyc;
        repeat (9) step();
        chk("post_rst_d_rdy_cyc", first_d_rdy - t0, 7);

        // Random traffic.
        rand_delay = 1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_addr = 32'h0040_0000 | ($urandom & 32'h0000_fffc);
                if_req = 1;
            end
            if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
                op = int'($urandom_range(0, 2));
                d_read = (op != 1);
                d_write = (op != 0);
                d_addr = 32'h0000_1000 | ($urandom & 32'h0000_0ffc);
                d_wdata = $urandom;
            end
        end
        for (int i = 0; i < 40 && (if_req || d_read || d_write); i++) step();
        chk("drain_idle", {if_req, d_read, d_write}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
